// File: rtl/led_blinker_multi.sv
// ---------------------------------------------------------------------------
// led_blinker_multi
//   Multi-channel LED sequencer. Each of NB_CH channels owns a programmable
//   half-period and a mode (off / on / blink / one-shot pulse). A global
//   sync input restarts the phase of every blinking channel, and each channel
//   reports a one-cycle tick whenever its LED toggles or a one-shot ends.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   cfg_we     in   one-cycle configuration write strobe
//   cfg_ch     in   target channel of the write (out-of-range writes ignored)
//   cfg_mode   in   00 off, 01 on, 10 blink, 11 one-shot
//   cfg_half   in   half-period in cycles (0 behaves as 1)
//   sync_i     in   restart phase of all blinking channels
//   led_o      out  registered LED drive, one bit per channel
//   tick_o     out  one-cycle pulse on every LED toggle / one-shot end
//   busy_o     out  high while a one-shot pulse is in progress
// ---------------------------------------------------------------------------
module led_blinker_multi #(
  parameter int          NB_CH        = 4,
  parameter int          CNT_W        = 27,
  parameter int unsigned DEFAULT_HALF = 100000000,
  localparam int         CH_W         = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             sync_i,
  output logic [NB_CH-1:0] led_o,
  output logic [NB_CH-1:0] tick_o,
  output logic [NB_CH-1:0] busy_o
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  mode_e            r_mode [NB_CH];
  logic [CNT_W-1:0] r_half [NB_CH];
  logic [CNT_W-1:0] r_cnt  [NB_CH];
  logic [NB_CH-1:0] r_led;
  logic [NB_CH-1:0] r_tick;
  logic [NB_CH-1:0] r_busy;

  mode_e            w_mode_nxt [NB_CH];
  logic [CNT_W-1:0] w_half_nxt [NB_CH];
  logic [CNT_W-1:0] w_cnt_nxt  [NB_CH];
  logic [CNT_W-1:0] w_last_cnt [NB_CH];
  logic [NB_CH-1:0] w_led_nxt;
  logic [NB_CH-1:0] w_tick_nxt;
  logic [NB_CH-1:0] w_busy_nxt;

  // Next-state logic. Priority per channel: config write, then sync (blink
  // channels only), then normal mode behaviour. A half-period of zero is
  // treated as one, so the terminal count is always reachable.
  always_comb begin
    w_led_nxt  = r_led;
    w_tick_nxt = '0;
    w_busy_nxt = r_busy;
    for (int i = 0; i < NB_CH; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_half_nxt[i] = r_half[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_last_cnt[i] = (r_half[i] == '0) ? '0 : r_half[i] - CNT_W'(1);

      if (cfg_we && (int'(cfg_ch) == i)) begin
        // Start value of the LED is 1 for on and one-shot, i.e. mode bit 0.
        w_mode_nxt[i] = mode_e'(cfg_mode);
        w_half_nxt[i] = cfg_half;
        w_cnt_nxt[i]  = '0;
        w_led_nxt[i]  = cfg_mode[0];
        w_busy_nxt[i] = (cfg_mode == 2'b11);
      end else if (sync_i && (r_mode[i] == MODE_BLINK)) begin
        w_cnt_nxt[i] = '0;
        w_led_nxt[i] = 1'b0;
      end else begin
        case (r_mode[i])
          MODE_OFF: begin
            w_cnt_nxt[i]  = '0;
            w_led_nxt[i]  = 1'b0;
            w_busy_nxt[i] = 1'b0;
          end
          MODE_ON: begin
            w_cnt_nxt[i]  = '0;
            w_led_nxt[i]  = 1'b1;
            w_busy_nxt[i] = 1'b0;
          end
          MODE_BLINK: begin
            w_busy_nxt[i] = 1'b0;
            if (r_cnt[i] == w_last_cnt[i]) begin
              w_cnt_nxt[i]  = '0;
              w_led_nxt[i]  = ~r_led[i];
              w_tick_nxt[i] = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
          MODE_ONESHOT: begin
            if (r_cnt[i] == w_last_cnt[i]) begin
              w_cnt_nxt[i]  = '0;
              w_led_nxt[i]  = 1'b0;
              w_busy_nxt[i] = 1'b0;
              w_tick_nxt[i] = 1'b1;
              w_mode_nxt[i] = MODE_OFF;
            end else begin
              w_cnt_nxt[i]  = r_cnt[i] + CNT_W'(1);
              w_led_nxt[i]  = 1'b1;
              w_busy_nxt[i] = 1'b1;
            end
          end
          default: begin
            w_cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  // State registers; reset aborts any pulse and returns every channel to
  // blinking at the default half-period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NB_CH; i++) begin
        r_mode[i] <= MODE_BLINK;
        r_half[i] <= HALF_RST;
        r_cnt[i]  <= '0;
      end
      r_led  <= '0;
      r_tick <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_half[i] <= w_half_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
      end
      r_led  <= w_led_nxt;
      r_tick <= w_tick_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign led_o  = r_led;
  assign tick_o = r_tick;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_led_blinker_multi.sv
// ---------------------------------------------------------------------------
// tb_led_blinker_multi
//   Self-checking bench for led_blinker_multi with three channels, 8-bit
//   counters and a default half-period of 4. Each vector row holds the inputs
//   for one clock edge and the hand-derived outputs expected after that edge.
//   Three channels give a 2-bit cfg_ch, so channel index 3 is out of range.
// ---------------------------------------------------------------------------
module tb_led_blinker_multi;

  logic       clk;
  logic       clkEn;
  logic       rstN;
  logic       cfgWe;
  logic [1:0] cfgCh;
  logic [1:0] cfgMode;
  logic [7:0] cfgHalf;
  logic       syncI;
  logic [2:0] led;
  logic [2:0] tick;
  logic [2:0] busy;

  int checks;
  int errors;

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] half;
    logic       sync;
    logic [2:0] led;
    logic [2:0] tick;
    logic [2:0] busy;
  } vec_t;

  typedef struct {
    logic [2:0] led;
    logic [2:0] tick;
    logic [2:0] busy;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];

  led_blinker_multi #(
    .NB_CH(3),
    .CNT_W(8),
    .DEFAULT_HALF(4)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rstN),
    .cfg_we(cfgWe),
    .cfg_ch(cfgCh),
    .cfg_mode(cfgMode),
    .cfg_half(cfgHalf),
    .sync_i(syncI),
    .led_o(led),
    .tick_o(tick),
    .busy_o(busy)
  );

  // Gated clock so the asynchronous reset can be exercised with no edges.
  initial clk = 1'b0;
  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic void addRow(input logic we, input logic [1:0] ch,
                                 input logic [1:0] mode, input logic [7:0] half,
                                 input logic sync, input logic [2:0] eLed,
                                 input logic [2:0] eTick, input logic [2:0] eBusy);
    vec_t v;
    v.we = we; v.ch = ch; v.mode = mode; v.half = half; v.sync = sync;
    v.led = eLed; v.tick = eTick; v.busy = eBusy;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input logic [2:0] eLed, input logic [2:0] eTick,
                               input logic [2:0] eBusy);
    addRow(1'b0, 2'd0, 2'b00, 8'd0, 1'b0, eLed, eTick, eBusy);
  endfunction

  task automatic compareBits(input string name, input int idx,
                             input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %b required %b", name, idx, act, exp);
    end
  endtask

  // Drive one row's inputs now and queue the outputs it should produce.
  task automatic applyStimulus(input int idx);
    exp_t e;
    cfgWe   = vecs[idx].we;
    cfgCh   = vecs[idx].ch;
    cfgMode = vecs[idx].mode;
    cfgHalf = vecs[idx].half;
    syncI   = vecs[idx].sync;
    e.led   = vecs[idx].led;
    e.tick  = vecs[idx].tick;
    e.busy  = vecs[idx].busy;
    e.idx   = idx;
    expQ.push_back(e);
  endtask

  // Wait for the active edge, then compare against the oldest queued entry.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue required one entry");
    end else begin
      e = expQ.pop_front();
      compareBits("led", e.idx, led, e.led);
      compareBits("tick", e.idx, tick, e.tick);
      compareBits("busy", e.idx, busy, e.busy);
    end
  endtask

  initial begin
    int splitIdx;
    checks  = 0;
    errors  = 0;
    clkEn   = 1'b1;
    rstN    = 1'b0;
    cfgWe   = 1'b0;
    cfgCh   = 2'd0;
    cfgMode = 2'b00;
    cfgHalf = 8'd0;
    syncI   = 1'b0;

    // Free-running blink, all channels at the default half-period.
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b111, 3'b111, 3'b000);
    idle(3'b111, 3'b000, 3'b000);
    idle(3'b111, 3'b000, 3'b000);
    idle(3'b111, 3'b000, 3'b000);
    idle(3'b000, 3'b111, 3'b000);
    // Channel 1 forced on; others keep blinking.
    addRow(1'b1, 2'd1, 2'b01, 8'd4, 1'b0, 3'b010, 3'b000, 3'b000);
    idle(3'b010, 3'b000, 3'b000);
    idle(3'b010, 3'b000, 3'b000);
    idle(3'b111, 3'b101, 3'b000);
    // Channel 0 one-shot of 3 cycles, then it stays off.
    addRow(1'b1, 2'd0, 2'b11, 8'd3, 1'b0, 3'b111, 3'b000, 3'b001);
    idle(3'b111, 3'b000, 3'b001);
    idle(3'b111, 3'b000, 3'b001);
    idle(3'b010, 3'b101, 3'b000);
    idle(3'b010, 3'b000, 3'b000);
    idle(3'b010, 3'b000, 3'b000);
    // Channel 0 blink with half 0: toggles every cycle, tick stays high.
    addRow(1'b1, 2'd0, 2'b10, 8'd0, 1'b0, 3'b010, 3'b000, 3'b000);
    idle(3'b111, 3'b101, 3'b000);
    idle(3'b110, 3'b001, 3'b000);
    idle(3'b111, 3'b001, 3'b000);
    idle(3'b110, 3'b001, 3'b000);
    addRow(1'b1, 2'd0, 2'b10, 8'd4, 1'b0, 3'b010, 3'b100, 3'b000);
    // Channel 1 blink half 6, then sync together with a write to channel 1.
    addRow(1'b1, 2'd1, 2'b10, 8'd6, 1'b0, 3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b101, 3'b101, 3'b000);
    idle(3'b101, 3'b000, 3'b000);
    addRow(1'b1, 2'd1, 2'b10, 8'd6, 1'b1, 3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b101, 3'b101, 3'b000);
    idle(3'b101, 3'b000, 3'b000);
    idle(3'b111, 3'b010, 3'b000);
    idle(3'b111, 3'b000, 3'b000);
    idle(3'b010, 3'b101, 3'b000);
    // Out-of-range channel write must change nothing.
    addRow(1'b1, 2'd3, 2'b00, 8'd1, 1'b0, 3'b010, 3'b000, 3'b000);
    idle(3'b010, 3'b000, 3'b000);
    idle(3'b010, 3'b000, 3'b000);
    idle(3'b101, 3'b111, 3'b000);
    idle(3'b101, 3'b000, 3'b000);
    idle(3'b101, 3'b000, 3'b000);
    idle(3'b101, 3'b000, 3'b000);
    // Write on channel 0's terminal count: write wins, no tick.
    addRow(1'b1, 2'd0, 2'b10, 8'd4, 1'b0, 3'b000, 3'b100, 3'b000);
    // One-shot on channel 1, re-triggered while busy.
    addRow(1'b1, 2'd1, 2'b11, 8'd3, 1'b0, 3'b010, 3'b000, 3'b010);
    idle(3'b010, 3'b000, 3'b010);
    addRow(1'b1, 2'd1, 2'b11, 8'd3, 1'b0, 3'b010, 3'b000, 3'b010);
    idle(3'b111, 3'b101, 3'b010);
    idle(3'b111, 3'b000, 3'b010);
    idle(3'b101, 3'b010, 3'b000);
    idle(3'b101, 3'b000, 3'b000);
    // Sync on a terminal-count cycle suppresses the toggle tick.
    addRow(1'b0, 2'd0, 2'b00, 8'd0, 1'b1, 3'b000, 3'b000, 3'b000);
    // Sync plus write to channel 2 (on): the write wins for channel 2.
    addRow(1'b1, 2'd2, 2'b01, 8'd4, 1'b1, 3'b100, 3'b000, 3'b000);
    // Long one-shot on channel 1, interrupted by reset below.
    addRow(1'b1, 2'd1, 2'b11, 8'd5, 1'b0, 3'b110, 3'b000, 3'b010);
    idle(3'b110, 3'b000, 3'b010);
    idle(3'b110, 3'b000, 3'b010);
    idle(3'b111, 3'b001, 3'b010);
    splitIdx = vecs.size();
    // After reset release every channel blinks at the default half-period.
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000);
    idle(3'b111, 3'b111, 3'b000);
    idle(3'b111, 3'b000, 3'b000);

    $display("[TB] reset phase");
    repeat (3) @(posedge clk);
    #1;
    compareBits("rst_led", -1, led, 3'b000);
    compareBits("rst_tick", -1, tick, 3'b000);
    compareBits("rst_busy", -1, busy, 3'b000);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < splitIdx; i++) begin
      applyStimulus(i);
      checkOutput();
    end

    // Asynchronous reset with the clock halted mid one-shot.
    $display("[TB] async reset with clock stopped");
    cfgWe = 1'b0;
    syncI = 1'b0;
    clkEn = 1'b0;
    #2;
    rstN = 1'b0;
    #3;
    compareBits("async_led", -2, led, 3'b000);
    compareBits("async_tick", -2, tick, 3'b000);
    compareBits("async_busy", -2, busy, 3'b000);
    #5;
    rstN = 1'b1;
    #5;
    clkEn = 1'b1;

    for (int i = splitIdx; i < vecs.size(); i++) begin
      applyStimulus(i);
      checkOutput();
    end

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
